// File: rtl/mem_io_ctrl.sv
// Memory/IO access controller: decodes the keyboard/display registers, runs the
// external memory handshake and returns a one-cycle R pulse per access.
module mem_io_ctrl #(
  parameter logic [15:0] KBSR_ADDR = 16'hFE00,
  parameter logic [15:0] KBDR_ADDR = 16'hFE02,
  parameter logic [15:0] DSR_ADDR  = 16'hFE04,
  parameter logic [15:0] DDR_ADDR  = 16'hFE06
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic        MIO_EN,
  input  logic        R_W,
  input  logic [15:0] MAR_IN,
  input  logic [15:0] MDR_IN,
  output logic [15:0] MIO_OUT,
  output logic        R,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  input  logic        kbd_valid,
  input  logic [7:0]  kbd_data,
  output logic        kbd_ready,
  output logic        dsp_valid,
  output logic [7:0]  dsp_data,
  input  logic        dsp_ack
);

  typedef enum logic [1:0] {IDLE, MEM, DEV, DONE} state_t;

  state_t      r_state, w_state_nxt;
  logic [15:0] r_addr, r_wdata;
  logic        r_we;
  logic [15:0] r_mio_out;
  logic        r_mem_req, r_mem_we;
  logic [15:0] r_mem_addr, r_mem_wdata;
  logic        r_kbd_full, r_kbd_ie;
  logic [7:0]  r_kbd_buf;
  logic        r_dsp_rdy, r_dsp_ie, r_dsp_valid;
  logic [7:0]  r_dsp_data;

  logic        w_in_is_dev;
  logic        w_sel_kbsr, w_sel_kbdr, w_sel_dsr, w_sel_ddr;
  logic        w_dev_rd, w_dev_wr;
  logic [15:0] w_dev_rdata;

  assign w_in_is_dev = (MAR_IN == KBSR_ADDR) || (MAR_IN == KBDR_ADDR) ||
                       (MAR_IN == DSR_ADDR)  || (MAR_IN == DDR_ADDR);

  assign w_sel_kbsr = (r_addr == KBSR_ADDR);
  assign w_sel_kbdr = (r_addr == KBDR_ADDR);
  assign w_sel_dsr  = (r_addr == DSR_ADDR);
  assign w_sel_ddr  = (r_addr == DDR_ADDR);

  assign w_dev_rd = (r_state == DEV) && !r_we;
  assign w_dev_wr = (r_state == DEV) && r_we;

  always_comb begin
    w_dev_rdata = 16'h0000;
    if (w_sel_kbsr)      w_dev_rdata = {r_kbd_full, r_kbd_ie, 14'b0};
    else if (w_sel_kbdr) w_dev_rdata = {8'b0, r_kbd_buf};
    else if (w_sel_dsr)  w_dev_rdata = {r_dsp_rdy, r_dsp_ie, 14'b0};
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (MIO_EN) w_state_nxt = w_in_is_dev ? DEV : MEM;
      MEM:  if (mem_ack) w_state_nxt = DONE;
      DEV:  w_state_nxt = DONE;
      DONE: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_addr      <= 16'h0000;
      r_wdata     <= 16'h0000;
      r_we        <= 1'b0;
      r_mio_out   <= 16'h0000;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 16'h0000;
      r_mem_wdata <= 16'h0000;
    end else begin
      case (r_state)
        IDLE: if (MIO_EN) begin
          r_addr  <= MAR_IN;
          r_wdata <= MDR_IN;
          r_we    <= R_W;
          if (!w_in_is_dev) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= R_W;
            r_mem_addr  <= MAR_IN;
            r_mem_wdata <= MDR_IN;
          end
        end
        MEM: if (mem_ack) begin
          if (!r_we) r_mio_out <= mem_rdata;
          r_mem_req <= 1'b0;
          r_mem_we  <= 1'b0;
        end
        DEV: if (!r_we) r_mio_out <= w_dev_rdata;
        default: ;
      endcase
    end
  end

  // A character offered while a KBDR read drains the buffer waits one edge,
  // because kbd_ready was low when the read happened.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_kbd_full <= 1'b0;
      r_kbd_buf  <= 8'h00;
      r_kbd_ie   <= 1'b0;
    end else begin
      if (kbd_valid && !r_kbd_full) begin
        r_kbd_buf  <= kbd_data;
        r_kbd_full <= 1'b1;
      end else if (w_dev_rd && w_sel_kbdr) begin
        r_kbd_full <= 1'b0;
      end
      if (w_dev_wr && w_sel_kbsr) r_kbd_ie <= r_wdata[14];
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_dsp_rdy   <= 1'b1;
      r_dsp_ie    <= 1'b0;
      r_dsp_valid <= 1'b0;
      r_dsp_data  <= 8'h00;
    end else begin
      if (w_dev_wr && w_sel_ddr && r_dsp_rdy) begin
        r_dsp_data  <= r_wdata[7:0];
        r_dsp_valid <= 1'b1;
        r_dsp_rdy   <= 1'b0;
      end else if (dsp_ack && r_dsp_valid) begin
        r_dsp_valid <= 1'b0;
        r_dsp_rdy   <= 1'b1;
      end
      if (w_dev_wr && w_sel_dsr) r_dsp_ie <= r_wdata[14];
    end
  end

  assign MIO_OUT   = r_mio_out;
  assign R         = (r_state == DONE);
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign kbd_ready = !r_kbd_full;
  assign dsp_valid = r_dsp_valid;
  assign dsp_data  = r_dsp_data;

endmodule

// File: tb/tb_mem_io_ctrl.sv
// Directed self-checking bench for mem_io_ctrl: memory handshake, device
// registers, keyboard/display handshakes and reset during an access.
module tb_mem_io_ctrl;
  logic        i_Clk = 1'b0;
  logic        i_Rst = 1'b1;
  logic        MIO_EN = 1'b0, R_W = 1'b0;
  logic [15:0] MAR_IN = '0, MDR_IN = '0;
  logic [15:0] MIO_OUT;
  logic        R, mem_req, mem_we;
  logic [15:0] mem_addr, mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        kbd_valid = 1'b0;
  logic [7:0]  kbd_data = '0;
  logic        kbd_ready, dsp_valid;
  logic [7:0]  dsp_data;
  logic        dsp_ack = 1'b0;

  int errors = 0;
  int checks = 0;

  int          g_rcyc, g_rcnt, g_reqcyc, g_holdbad;
  logic [15:0] g_rout, g_addr, g_wdata;
  logic        g_we;

  mem_io_ctrl dut (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .MIO_EN(MIO_EN), .R_W(R_W),
    .MAR_IN(MAR_IN), .MDR_IN(MDR_IN), .MIO_OUT(MIO_OUT), .R(R),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .kbd_valid(kbd_valid), .kbd_data(kbd_data), .kbd_ready(kbd_ready),
    .dsp_valid(dsp_valid), .dsp_data(dsp_data), .dsp_ack(dsp_ack)
  );

  always #5 i_Clk = ~i_Clk;

  // One access; ack_lat is the MEM cycle (1 = first) in which mem_ack is given.
  task automatic access(input logic we, input logic [15:0] addr, input logic [15:0] wd,
                        input int ack_lat, input logic [15:0] rd);
    int memcyc;
    memcyc = 0;
    g_rcyc = -1; g_rcnt = 0; g_reqcyc = 0; g_holdbad = 0;
    g_we = 1'bx; g_addr = 'x; g_wdata = 'x; g_rout = 'x;
    @(negedge i_Clk);
    MIO_EN = 1'b1; R_W = we; MAR_IN = addr; MDR_IN = wd; mem_rdata = rd;
    for (int c = 1; c <= 40; c++) begin
      @(posedge i_Clk); #1;
      if (mem_req) begin
        g_reqcyc++;
        memcyc++;
        if (mem_addr !== addr || mem_wdata !== wd || mem_we !== we) g_holdbad++;
      end
      mem_ack = mem_req && (memcyc == ack_lat);
      if (mem_ack) begin
        g_we = mem_we; g_addr = mem_addr; g_wdata = mem_wdata;
      end
      if (R) begin
        g_rcnt++;
        if (g_rcyc < 0) begin
          g_rcyc = c; g_rout = MIO_OUT; MIO_EN = 1'b0;
        end
      end
      if (g_rcyc >= 0 && c >= g_rcyc + 2) break;
    end
    MIO_EN = 1'b0; mem_ack = 1'b0;
    checks++;
    if (g_rcyc < 0) begin
      errors++; $display("FAIL access_timeout addr=%h: R not seen within 40 cycles", addr);
    end
  endtask

  task automatic test_reset();
    i_Rst = 1'b1;
    repeat (2) @(posedge i_Clk);
    #1;
    checks++; if (MIO_OUT !== 16'h0) begin errors++; $display("FAIL rst_mio_out got=%h exp=0000", MIO_OUT); end
    checks++; if (R !== 1'b0) begin errors++; $display("FAIL rst_r got=%b exp=0", R); end
    checks++; if ({mem_req, mem_we} !== 2'b00) begin errors++; $display("FAIL rst_mem_req_we got=%b exp=00", {mem_req, mem_we}); end
    checks++; if ({mem_addr, mem_wdata} !== 32'h0) begin errors++; $display("FAIL rst_mem_addr_wdata got=%h exp=0", {mem_addr, mem_wdata}); end
    checks++; if (kbd_ready !== 1'b1) begin errors++; $display("FAIL rst_kbd_ready got=%b exp=1", kbd_ready); end
    checks++; if ({dsp_valid, dsp_data} !== 9'h0) begin errors++; $display("FAIL rst_dsp got=%h exp=000", {dsp_valid, dsp_data}); end
    @(negedge i_Clk); i_Rst = 1'b0;
  endtask

  task automatic test_mem_read();
    access(1'b0, 16'h3000, 16'h0000, 2, 16'h1234);
    checks++; if (g_rcyc !== 3) begin errors++; $display("FAIL mem_read_latency got=%0d exp=3", g_rcyc); end
    checks++; if (g_rcnt !== 1) begin errors++; $display("FAIL mem_read_rpulses got=%0d exp=1", g_rcnt); end
    checks++; if (g_we !== 1'b0 || g_addr !== 16'h3000) begin errors++; $display("FAIL mem_read_bus we=%b addr=%h exp 0/3000", g_we, g_addr); end
    checks++; if (g_rout !== 16'h1234) begin errors++; $display("FAIL mem_read_data got=%h exp=1234", g_rout); end
    checks++; if (g_holdbad !== 0) begin errors++; $display("FAIL mem_read_hold got=%0d exp=0", g_holdbad); end
  endtask

  task automatic test_mem_write();
    access(1'b1, 16'h3001, 16'hBEEF, 3, 16'hDEAD);
    checks++; if (g_rcyc !== 4) begin errors++; $display("FAIL mem_write_latency got=%0d exp=4", g_rcyc); end
    checks++; if (g_we !== 1'b1 || g_wdata !== 16'hBEEF || g_addr !== 16'h3001) begin errors++; $display("FAIL mem_write_bus we=%b addr=%h wd=%h exp 1/3001/beef", g_we, g_addr, g_wdata); end
    checks++; if (g_holdbad !== 0 || g_reqcyc !== 3) begin errors++; $display("FAIL mem_write_hold bad=%0d reqcyc=%0d exp 0/3", g_holdbad, g_reqcyc); end
    checks++; if (g_rcnt !== 1) begin errors++; $display("FAIL mem_write_rpulses got=%0d exp=1", g_rcnt); end
    checks++; if (MIO_OUT !== 16'h1234) begin errors++; $display("FAIL mem_write_mio_kept got=%h exp=1234", MIO_OUT); end
    checks++; if (mem_we !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL mem_write_release req=%b we=%b exp 0/0", mem_req, mem_we); end
  endtask

  task automatic test_kbd();
    @(negedge i_Clk); kbd_valid = 1'b1; kbd_data = 8'h41;
    @(posedge i_Clk); #1;
    kbd_valid = 1'b0; kbd_data = 8'h00;
    checks++; if (kbd_ready !== 1'b0) begin errors++; $display("FAIL kbd_ready_full got=%b exp=0", kbd_ready); end
    access(1'b0, 16'hFE00, 16'h0, 1, 16'h0);
    checks++; if (g_rout !== 16'h8000) begin errors++; $display("FAIL kbsr_full got=%h exp=8000", g_rout); end
    checks++; if (g_rcyc !== 2 || g_reqcyc !== 0) begin errors++; $display("FAIL dev_timing rcyc=%0d reqcyc=%0d exp 2/0", g_rcyc, g_reqcyc); end
    kbd_valid = 1'b1; kbd_data = 8'h42;
    access(1'b0, 16'hFE02, 16'h0, 1, 16'h0);
    kbd_valid = 1'b0; kbd_data = 8'h00;
    checks++; if (g_rout !== 16'h0041) begin errors++; $display("FAIL kbdr_read got=%h exp=0041", g_rout); end
    checks++; if (kbd_ready !== 1'b0) begin errors++; $display("FAIL kbd_refill_ready got=%b exp=0", kbd_ready); end
    access(1'b0, 16'hFE02, 16'h0, 1, 16'h0);
    checks++; if (g_rout !== 16'h0042) begin errors++; $display("FAIL kbdr_read_second got=%h exp=0042", g_rout); end
    access(1'b0, 16'hFE00, 16'h0, 1, 16'h0);
    checks++; if (g_rout !== 16'h0000) begin errors++; $display("FAIL kbsr_empty got=%h exp=0000", g_rout); end
    checks++; if (kbd_ready !== 1'b1) begin errors++; $display("FAIL kbd_ready_empty got=%b exp=1", kbd_ready); end
  endtask

  task automatic test_dsp();
    access(1'b1, 16'hFE06, 16'h0058, 1, 16'h0);
    checks++; if (dsp_valid !== 1'b1 || dsp_data !== 8'h58) begin errors++; $display("FAIL ddr_write valid=%b data=%h exp 1/58", dsp_valid, dsp_data); end
    checks++; if (MIO_OUT !== 16'h0000 || g_reqcyc !== 0) begin errors++; $display("FAIL ddr_write_side mio=%h reqcyc=%0d exp 0000/0", MIO_OUT, g_reqcyc); end
    access(1'b0, 16'hFE04, 16'h0, 1, 16'h0);
    checks++; if (g_rout !== 16'h0000) begin errors++; $display("FAIL dsr_busy got=%h exp=0000", g_rout); end
    access(1'b1, 16'hFE06, 16'h0077, 1, 16'h0);
    checks++; if (dsp_data !== 8'h58 || dsp_valid !== 1'b1 || g_rcnt !== 1) begin errors++; $display("FAIL ddr_drop data=%h valid=%b r=%0d exp 58/1/1", dsp_data, dsp_valid, g_rcnt); end
    @(negedge i_Clk); dsp_ack = 1'b1;
    @(negedge i_Clk); dsp_ack = 1'b0;
    checks++; if (dsp_valid !== 1'b0) begin errors++; $display("FAIL dsp_ack_clear got=%b exp=0", dsp_valid); end
    access(1'b0, 16'hFE04, 16'h0, 1, 16'h0);
    checks++; if (g_rout !== 16'h8000) begin errors++; $display("FAIL dsr_ready got=%h exp=8000", g_rout); end
    access(1'b0, 16'hFE06, 16'h0, 1, 16'h0);
    checks++; if (g_rout !== 16'h0000) begin errors++; $display("FAIL ddr_read got=%h exp=0000", g_rout); end
  endtask

  task automatic test_ie();
    access(1'b1, 16'hFE00, 16'hFFFF, 1, 16'h0);
    access(1'b0, 16'hFE00, 16'h0, 1, 16'h0);
    checks++; if (g_rout !== 16'h4000) begin errors++; $display("FAIL kbsr_ie got=%h exp=4000", g_rout); end
    @(negedge i_Clk); kbd_valid = 1'b1; kbd_data = 8'h5A;
    @(negedge i_Clk); kbd_valid = 1'b0;
    access(1'b0, 16'hFE00, 16'h0, 1, 16'h0);
    checks++; if (g_rout !== 16'hC000) begin errors++; $display("FAIL kbsr_ie_full got=%h exp=c000", g_rout); end
    access(1'b1, 16'hFE02, 16'h0011, 1, 16'h0);
    access(1'b0, 16'hFE02, 16'h0, 1, 16'h0);
    checks++; if (g_rout !== 16'h005A) begin errors++; $display("FAIL kbdr_write_ignored got=%h exp=005a", g_rout); end
    access(1'b1, 16'hFE04, 16'h4000, 1, 16'h0);
    access(1'b0, 16'hFE04, 16'h0, 1, 16'h0);
    checks++; if (g_rout !== 16'hC000 || g_reqcyc !== 0) begin errors++; $display("FAIL dsr_ie got=%h reqcyc=%0d exp c000/0", g_rout, g_reqcyc); end
  endtask

  task automatic test_reset_mid();
    int rseen;
    rseen = 0;
    @(negedge i_Clk);
    MIO_EN = 1'b1; R_W = 1'b0; MAR_IN = 16'h3100; mem_rdata = 16'h9999;
    repeat (2) @(posedge i_Clk);
    #1;
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL mid_req_before got=%b exp=1", mem_req); end
    @(negedge i_Clk); i_Rst = 1'b1; #1;
    checks++; if (mem_req !== 1'b0 || R !== 1'b0) begin errors++; $display("FAIL mid_rst_immediate req=%b r=%b exp 0/0", mem_req, R); end
    MIO_EN = 1'b0;
    @(negedge i_Clk); i_Rst = 1'b0;
    repeat (5) begin
      @(posedge i_Clk); #1;
      if (R) rseen++;
    end
    checks++; if (rseen !== 0 || mem_req !== 1'b0) begin errors++; $display("FAIL mid_no_r rseen=%0d req=%b exp 0/0", rseen, mem_req); end
    access(1'b0, 16'hFE00, 16'h0, 1, 16'h0);
    checks++; if (g_rout !== 16'h0000) begin errors++; $display("FAIL mid_ie_cleared got=%h exp=0000", g_rout); end
    access(1'b0, 16'h4000, 16'h0, 1, 16'h5555);
    checks++; if (g_rout !== 16'h5555 || g_rcyc !== 2) begin errors++; $display("FAIL post_rst_read data=%h rcyc=%0d exp 5555/2", g_rout, g_rcyc); end
  endtask

  initial begin
    test_reset();
    test_mem_read();
    test_mem_write();
    test_kbd();
    test_dsp();
    test_ie();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_io_ctrl.md
Name: mem_io_ctrl

Overview:
- Memory/IO access controller sitting between MAR/MDR and external memory plus keyboard/display devices.
- Takes the address held in MAR and the data held in MDR.
- Decodes memory-mapped device registers: KBSR xFE00, KBDR xFE02, DSR xFE04, DDR xFE06.
- Runs the external memory handshake and produces the read word that feeds MDR through MIOMUX.
- Returns a one-cycle ready pulse R to the control FSM.
- Owns the keyboard/display status bits as a proper clocked handshake.

Parameters:
- KBSR_ADDR, 16'hFE00, keyboard status register address
- KBDR_ADDR, 16'hFE02, keyboard data register address
- DSR_ADDR, 16'hFE04, display status register address
- DDR_ADDR, 16'hFE06, display data register address

Ports:
- i_Clk  in  1  system clock, all state updates on rising edge
- i_Rst  in  1  asynchronous active-high reset
- MIO_EN  in  1  access request from control FSM, held high until R is seen
- R_W  in  1  1 = write, 0 = read; sampled with MIO_EN in IDLE
- MAR_IN  in  16  access address
- MDR_IN  in  16  write data
- MIO_OUT  out  16  read data to MIOMUX
- R  out  1  access complete, one-cycle pulse
- mem_req  out  1  external memory request
- mem_we  out  1  external memory write enable
- mem_addr  out  16  external memory address
- mem_wdata  out  16  external memory write data
- mem_rdata  in  16  external memory read data, valid with mem_ack
- mem_ack  in  1  external memory completion
- kbd_valid  in  1  keyboard offers a character
- kbd_data  in  8  keyboard character
- kbd_ready  out  1  controller can accept a character
- dsp_valid  out  1  display character pending
- dsp_data  out  8  display character
- dsp_ack  in  1  display consumed the character

Behaviour:
- Reset values (asynchronous, immediate on i_Rst):
  - State IDLE.
  - MIO_OUT=0, R=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - kbd_full=0, kbd_buf=0, kbd_ie=0, so kbd_ready=1.
  - dsp_rdy=1, dsp_ie=0, dsp_valid=0, dsp_data=0.
- State machine: IDLE, MEM, DEV, DONE.
- IDLE:
  - When MIO_EN=1, latch MAR_IN, MDR_IN and R_W.
  - Address equal to any of the four device addresses -> DEV.
  - Any other address -> MEM. Assert mem_req, drive mem_addr/mem_wdata, and set mem_we=R_W on the same edge.
- MEM:
  - Hold mem_req and the address/data steady until mem_ack=1.
  - On the mem_ack edge: a read loads MIO_OUT<=mem_rdata; clear mem_req and mem_we; -> DONE.
  - No timeout. Minimum access latency is 3 cycles from MIO_EN to R (IDLE, MEM, DONE) with mem_ack in the first MEM cycle.
- DEV: one cycle, then -> DONE.
  - Read KBSR: MIO_OUT = {kbd_full, kbd_ie, 14'b0}.
  - Read KBDR: MIO_OUT = {8'b0, kbd_buf}; clear kbd_full.
  - Read DSR: MIO_OUT = {dsp_rdy, dsp_ie, 14'b0}.
  - Read DDR: MIO_OUT = 0.
  - Write KBSR: kbd_ie <= MDR_IN[14], all other bits ignored.
  - Write DSR: dsp_ie <= MDR_IN[14].
  - Write KBDR: ignored.
  - Write DDR with dsp_rdy=1: dsp_data <= MDR_IN[7:0], dsp_valid <= 1, dsp_rdy <= 0.
  - Write DDR with dsp_rdy=0: data dropped, no state change.
  - Every DEV access completes normally.
- DONE: R=1 for exactly one cycle, MIO_OUT held; -> IDLE unconditionally. A new access needs MIO_EN sampled again in IDLE.
- Writes leave MIO_OUT unchanged.
- Keyboard handshake:
  - kbd_ready = !kbd_full, combinational.
  - kbd_valid=1 while kbd_full=0: kbd_buf <= kbd_data, kbd_full <= 1.
  - kbd_valid while kbd_full=1 is ignored; the device must hold its character.
  - A KBDR read and kbd_valid in the same cycle: the read clears kbd_full, and the character is accepted on the next edge since kbd_ready was 0.
- Display handshake:
  - dsp_ack while dsp_valid=1: dsp_valid <= 0, dsp_rdy <= 1.
  - dsp_ack while dsp_valid=0 is ignored.
- Reset mid-access: mem_req drops immediately, the pending access is abandoned, and R is never issued.

Test Plan:
- Memory read at x3000, mem_ack 2 cycles after mem_req with mem_rdata=x1234 -> mem_we=0, MIO_OUT=x1234, R pulses once, 4 cycles after MIO_EN.
- Memory write x3001 <- xBEEF -> mem_we=1, mem_wdata=xBEEF held until mem_ack; R one cycle; MIO_OUT unchanged.
- kbd_valid with kbd_data=x41 -> kbd_ready=0; KBSR read = x8000; KBDR read = x0041; next KBSR read = x0000; kbd_ready=1.
- DDR write x0058 -> dsp_valid=1, dsp_data=x58, DSR read = x0000. A second DDR write before ack is dropped. dsp_ack -> DSR read = x8000.
- Write KBSR xFFFF -> KBSR read = x4000 (or xC000 if a character is buffered); mem_req stays 0 for all device accesses.
- Assert i_Rst during MEM with mem_req=1 -> mem_req=0 immediately, no R; the next read after reset completes normally.
